// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: data widths, PC step and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs; head is read straight from storage, no bypass.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [INSTR_W-1:0]     i_data,
  input  logic [ADDR_W-1:0]      i_pc,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [INSTR_W-1:0]     o_data,
  output logic [ADDR_W-1:0]      o_pc,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0]  r_pc   [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage is reset so the head outputs read as zero while the FIFO is in reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_data[r_wr_ptr] <= i_data;
      r_pc[r_wr_ptr]   <= i_pc;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_data[r_rd_ptr];
  assign o_pc    = r_pc[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests, prefetch FIFO, redirect with
// drain of stale responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        CLB,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  output logic        rsp_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_depth_check
    $error("fetch_unit: DEPTH must be 2, 4 or 8");
  end

  fetch_state_e       r_state;
  fetch_state_e       w_state_d;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  w_fetch_pc_d;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   w_outstanding_d;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [CNT_W-1:0]   w_drop_cnt_d;
  logic               r_run_en;
  logic               r_rsp_err;

  // Issue-order PC tags for requests still waiting on a response.
  logic [ADDR_W-1:0]  r_aq [DEPTH];
  logic [PTR_W-1:0]   r_aq_wr;
  logic [PTR_W-1:0]   r_aq_rd;

  logic               w_credit;
  logic               w_fire;
  logic               w_rsp_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_valid;
  logic [CNT_W-1:0]   w_fifo_count;

  // Outstanding plus buffered never exceeds DEPTH, so every response has a FIFO slot.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(DEPTH);

  assign imem_req_valid = r_run_en && (r_state == RUN) && !redirect_valid && w_credit;
  assign imem_addr      = r_fetch_pc;

  assign w_fire   = imem_req_valid && imem_req_ready;
  assign w_rsp_ok = imem_rsp_valid && (r_outstanding != '0);
  assign w_push   = w_rsp_ok && (r_state == RUN) && !redirect_valid;
  assign w_pop    = w_fifo_valid && dec_ready && !redirect_valid;

  always_comb begin
    w_state_d       = r_state;
    w_fetch_pc_d    = r_fetch_pc;
    w_drop_cnt_d    = r_drop_cnt;
    w_outstanding_d = r_outstanding + CNT_W'(w_fire) - CNT_W'(w_rsp_ok);
    if (w_fire) w_fetch_pc_d = r_fetch_pc + PC_STEP;
    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_fetch_pc_d = align_pc(redirect_pc);
          w_drop_cnt_d = r_outstanding - CNT_W'(w_rsp_ok);
          w_state_d    = (w_drop_cnt_d != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (redirect_valid) w_fetch_pc_d = align_pc(redirect_pc);
        if (imem_rsp_valid && (r_drop_cnt != '0)) w_drop_cnt_d = r_drop_cnt - CNT_W'(1);
        w_state_d = (w_drop_cnt_d != '0) ? DRAIN : RUN;
      end
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_state       <= RUN;
      r_fetch_pc    <= align_pc(RESET_PC);
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_run_en      <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_fetch_pc    <= w_fetch_pc_d;
      r_outstanding <= w_outstanding_d;
      r_drop_cnt    <= w_drop_cnt_d;
      r_run_en      <= 1'b1;
      r_rsp_err     <= r_rsp_err || (imem_rsp_valid && (r_outstanding == '0));
    end
  end

  // A redirect orphans every queued tag; those responses are dropped via drop_cnt instead.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else if (redirect_valid) begin
      r_aq_rd <= r_aq_wr;
    end else begin
      if (w_fire) r_aq_wr <= r_aq_wr + PTR_W'(1);
      if (w_push) r_aq_rd <= r_aq_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !redirect_valid) r_aq[r_aq_wr] <= r_fetch_pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .i_rst_n (CLB),
    .i_push  (w_push),
    .i_data  (imem_rdata),
    .i_pc    (r_aq[r_aq_rd]),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_valid (w_fifo_valid),
    .o_data  (instr),
    .o_pc    (instr_pc),
    .o_count (w_fifo_count)
  );

  assign instr_valid = w_fifo_valid;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle corner sequences and a
// randomized run against an epoch-tagged stream model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        clb;
  logic        req_ready, rsp_valid, redir_valid, dec_ready;
  logic [31:0] rdata, redir_pc;
  logic        req_valid, instr_valid, rsp_err;
  logic [31:0] addr, instr, instr_pc;
  logic        req_valid2, instr_valid2, rsp_err2;
  logic [31:0] addr2, instr2, instr_pc2;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .CLB(clb),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rdata(rdata),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .rsp_err(rsp_err)
  );

  // Wrap-around instance: always ready, never answered.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .CLB(clb),
    .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_addr(addr2),
    .imem_rsp_valid(1'b0), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
    .dec_ready(1'b0), .rsp_err(rsp_err2)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [31:0] q_addr[$];
  int          q_epoch[$];
  int          epoch, fifo_model;
  logic [31:0] exp_fetch, exp_pc, last_pop_pc, first_fire_addr;
  logic        prev_valid, prev_fire;
  logic [31:0] prev_addr;
  int          fires, pops;

  // Stimulus controls: 0 = asserted/immediate, 1 = deasserted/held, 2 = random
  int          ready_mode, dec_mode, rsp_mode;
  logic        redir_req, spur_req;
  logic [31:0] redir_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int  q_n, f_n;
    bit  old, s_fire, s_pop;
    @(posedge clk);
    #1;
    req_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    dec_ready = (dec_mode == 0) ? 1'b1 : (dec_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
    rsp_valid = 1'b0;
    rdata     = 32'h0;
    if (spur_req) begin
      rsp_valid = 1'b1;
      rdata     = 32'hDEAD_BEEF;
      spur_req  = 1'b0;
    end else if (q_addr.size() > 0 &&
                 (rsp_mode == 0 || (rsp_mode == 2 && $urandom_range(0, 2) != 0))) begin
      rsp_valid = 1'b1;
      rdata     = mem_word(q_addr[0]);
    end
    redir_valid = redir_req;
    redir_pc    = redir_tgt;
    redir_req   = 1'b0;
    @(negedge clk);
    s_fire = req_valid && req_ready;
    s_pop  = instr_valid && dec_ready && !redir_valid;
    q_n    = q_addr.size();
    f_n    = fifo_model;
    old    = 1'b0;
    foreach (q_epoch[k]) if (q_epoch[k] != epoch) old = 1'b1;
    if (req_valid) begin
      chk("req_credit", 32'(q_n + f_n < DEPTH), 32'd1);
      chk("req_not_in_redirect_or_drain", 32'(!redir_valid && !old), 32'd1);
    end
    if (prev_valid && !prev_fire && !redir_valid) begin
      chk("req_hold_valid", 32'(req_valid), 32'd1);
      chk("req_hold_addr", addr, prev_addr);
    end
    if (rsp_valid && q_n > 0) begin
      if (q_epoch[0] == epoch && !redir_valid) fifo_model++;
      void'(q_addr.pop_front());
      void'(q_epoch.pop_front());
    end
    if (s_pop) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, mem_word(exp_pc));
      last_pop_pc = instr_pc;
      exp_pc      = exp_pc + 32'd4;
      fifo_model--;
      pops++;
    end
    if (s_fire) begin
      chk("fetch_addr", addr, exp_fetch);
      if (fires == 0) first_fire_addr = addr;
      q_addr.push_back(addr);
      q_epoch.push_back(epoch);
      exp_fetch = exp_fetch + 32'd4;
      fires++;
    end
    if (redir_valid) begin
      epoch++;
      fifo_model = 0;
      exp_fetch  = {redir_pc[31:2], 2'b00};
      exp_pc     = exp_fetch;
    end
    prev_valid = req_valid;
    prev_addr  = addr;
    prev_fire  = s_fire;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    clb         = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rdata       = 32'h0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    dec_ready   = 1'b0;
    redir_req   = 1'b0;
    spur_req    = 1'b0;
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_addr_wrap_inst", addr2, 32'hFFFF_FFF8);
    chk("rst_req_valid_wrap_inst", 32'(req_valid2), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clb = 1'b1;
    q_addr.delete();
    q_epoch.delete();
    epoch      = 0;
    fifo_model = 0;
    exp_fetch  = 32'h0;
    exp_pc     = 32'h0;
    prev_valid = 1'b0;
    prev_fire  = 1'b0;
    fires      = 0;
    pops       = 0;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic        rv2;
    logic [31:0] addr2;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycles 1..6 after reset release: ready=1, 1-cycle memory, dec_ready=1.
    tbl[0] = '{1'b1, 32'h00, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8};
    tbl[1] = '{1'b1, 32'h04, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC};
    tbl[2] = '{1'b1, 32'h08, 1'b1, 32'h0, 1'b1, 32'h0000_0000};
    tbl[3] = '{1'b1, 32'h0C, 1'b1, 32'h4, 1'b1, 32'h0000_0004};
    tbl[4] = '{1'b1, 32'h10, 1'b1, 32'h8, 1'b0, 32'h0000_0008};
    tbl[5] = '{1'b1, 32'h14, 1'b1, 32'hC, 1'b0, 32'h0000_0008};

    clb = 1'b0; redir_tgt = 32'h0; redir_req = 1'b0; spur_req = 1'b0;
    ready_mode = 0; dec_mode = 0; rsp_mode = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("tbl%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("tbl%0d_wrap_req_valid", i), 32'(req_valid2), 32'(tbl[i].rv2));
      chk($sformatf("tbl%0d_wrap_addr", i), addr2, tbl[i].addr2);
    end
    pops = 0;
    repeat (8) step();
    chk("throughput_pops", 32'(pops), 32'd8);

    // Decode stalled: credit allows exactly DEPTH fires, then issue resumes on dec_ready.
    do_reset();
    dec_mode = 1;
    repeat (12) step();
    chk("stall_dec_fires", 32'(fires), 32'd4);
    chk("stall_dec_req_valid", 32'(req_valid), 32'd0);
    chk("stall_dec_instr_valid", 32'(instr_valid), 32'd1);
    dec_mode = 0;
    fires = 0;
    for (int i = 0; i < 10 && fires == 0; i++) step();
    chk("stall_dec_resume", 32'(fires > 0), 32'd1);

    // Memory not ready: request and address hold.
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_mem_req_valid", 32'(req_valid), 32'd1);
      chk("stall_mem_addr", addr, 32'h0);
    end
    ready_mode = 0;
    step();
    chk("stall_mem_release_fire", 32'(fires), 32'd1);

    // Redirect with two requests outstanding; one response lands in the redirect cycle.
    do_reset();
    rsp_mode = 1;
    step();
    step();
    chk("redir_outstanding", 32'(q_addr.size()), 32'd2);
    redir_req = 1'b1;
    redir_tgt = 32'h0000_1002;
    rsp_mode  = 0;
    step();
    chk("redir_retracts_req", 32'(req_valid), 32'd0);
    fires = 0;
    pops  = 0;
    for (int i = 0; i < 20 && pops == 0; i++) step();
    chk("redir_pop_seen", 32'(pops > 0), 32'd1);
    chk("redir_first_fetch", first_fire_addr, 32'h0000_1000);
    chk("redir_first_instr_pc", last_pop_pc, 32'h0000_1000);

    // Spurious response right after reset.
    do_reset();
    rsp_mode = 1;
    spur_req = 1'b1;
    step();
    step();
    chk("spur_rsp_err", 32'(rsp_err), 32'd1);
    chk("spur_fifo_empty0", 32'(instr_valid), 32'd0);
    step();
    chk("spur_fifo_empty1", 32'(instr_valid), 32'd0);
    rsp_mode = 0;
    pops = 0;
    repeat (6) step();
    chk("spur_rsp_err_sticky", 32'(rsp_err), 32'd1);
    chk("spur_stream_continues", 32'(pops > 0), 32'd1);

    // Randomized run with redirects (some unaligned, some near the wrap) and a mid-run reset.
    do_reset();
    ready_mode = 2; dec_mode = 2; rsp_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if ($urandom_range(0, 29) == 0) begin
        redir_req = 1'b1;
        redir_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      end
      step();
    end
    chk("random_progress", 32'(pops > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, sets the prefetch FIFO entry count; the only legal values are 2, 4 and 8.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 CLB  in  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_ready  in  1  memory accepts the request.
REQ-007 imem_addr  out  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  in  1  read data returned; responses are in order.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect_valid  in  1  branch/jump from the control FSM.
REQ-011 redirect_pc  in  32  new fetch target.
REQ-012 instr_valid  out  1  FIFO head holds an instruction for decode.
REQ-013 instr  out  32  instruction word at the FIFO head.
REQ-014 instr_pc  out  32  address of instr.
REQ-015 dec_ready  in  1  decode consumes the head instruction.
REQ-016 rsp_err  out  1  sticky flag: a response arrived with nothing outstanding.

Function
REQ-017 A request fires when imem_req_valid and imem_req_ready are both high in the same cycle; fetch_pc increments by 4 on every fire.
REQ-018 imem_req_valid is high only when state=RUN, redirect_valid=0, and outstanding+fifo_count < DEPTH (credit rule).
REQ-019 Once raised, imem_req_valid holds, with imem_addr stable, until it fires; the only exception is a redirect, which retracts it.
REQ-020 imem_addr equals fetch_pc; the PC wraps: 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
REQ-021 The outstanding counter increments on each fire and decrements on each imem_rsp_valid; both events in one cycle leave it unchanged.
REQ-022 In RUN, each response is written into the FIFO with {imem_rdata, pc}; the PC tag comes from an internal issue-order address queue.
REQ-023 The FIFO has a registered output; instr_valid rises exactly one cycle after the imem_rsp_valid that fills an empty FIFO (no bypass path).
REQ-024 The FIFO pops when instr_valid and dec_ready are both high; a push and a pop in the same cycle keep the count unchanged.
REQ-025 The FSM has two states, RUN and DRAIN.
REQ-026 Redirect in RUN: flush the FIFO; fetch_pc <= {redirect_pc[31:2], 2'b00}; drop_cnt <= outstanding minus any response arriving this cycle.
REQ-027 After the redirect, the FSM goes to DRAIN if drop_cnt is nonzero, otherwise it stays in RUN.
REQ-028 In DRAIN, no requests are issued; each response is discarded and decrements drop_cnt; the FSM returns to RUN in the cycle after drop_cnt reaches 0.
REQ-029 A redirect in DRAIN reloads fetch_pc only; drop_cnt continues to decrement.
REQ-030 A redirect in the same cycle as a pop or a push wins: the FIFO is empty next cycle and no pop is acknowledged.
REQ-031 A response with outstanding=0 is ignored and sets rsp_err, which stays set until reset.

Reset
REQ-032 On CLB low: fetch_pc=RESET_PC, state=RUN, FIFO empty, outstanding=0, drop_cnt=0.
REQ-033 All outputs are 0 during reset except imem_addr, which is RESET_PC.
REQ-034 A reset asserted mid-operation abandons all in-flight responses; memory returning stale data after reset is the integrator's responsibility.
REQ-035 imem_req_valid may first assert in the first clk edge after CLB deasserts.

Structure
REQ-036 The shared processor package holds INSTR_W=32, PC_STEP=4, and the fetch state enum {RUN, DRAIN}.
REQ-037 One sub-module, fetch_fifo, is instantiated for the parameterized synchronous FIFO (push, pop, flush, count, data+pc).

Verification
REQ-038 Reset release, memory always ready, 1-cycle response, dec_ready=1 -> addresses 0,4,8,... issue; first instr_valid 2 cycles after the first fire; throughput is 1 instruction per cycle.
REQ-039 dec_ready=0 with DEPTH=4 -> exactly 4 requests fire, then imem_req_valid stays 0; raising dec_ready resumes issue.
REQ-040 Redirect to 32'h0000_1002 with 2 requests outstanding -> enter DRAIN, discard 2 responses, next fetch at 32'h0000_1000, instr_pc matches.
REQ-041 imem_req_ready held low 5 cycles -> imem_req_valid and imem_addr stay stable; fetch_pc does not advance.
REQ-042 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-043 Spurious imem_rsp_valid right after reset -> rsp_err=1, FIFO stays empty.
